// File: rtl/fir_mac_seq.sv
// Sequential multi-channel FIR multiply-accumulate engine.
// One coefficient is shared by all channels each cycle. Coefficients come
// from an external ROM with one cycle of read latency. Each finished run is
// rounded, optionally saturated, and presented on out_data with an out_vld
// pulse.
module fir_mac_seq #(
  parameter int NUM_TAPS = 1021,
  parameter int NUM_CH   = 2,
  parameter int DATA_W   = 16,
  parameter int COEF_W   = 16,
  parameter int ACC_W    = 40,
  parameter int SAT_EN   = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sequencing,
  input  logic [NUM_CH*DATA_W-1:0]   smpl_in,
  input  logic [COEF_W-1:0]          coef,
  output logic [$clog2(NUM_TAPS)-1:0] coef_addr,
  output logic [NUM_CH*DATA_W-1:0]   out_data,
  output logic                       out_vld,
  output logic                       busy,
  output logic                       abort
);

  localparam int AW = $clog2(NUM_TAPS);
  localparam int PW = DATA_W + COEF_W;

  // Rounding constant 2^(COEF_W-2) and output clamp limits, all ACC_W wide.
  localparam logic signed [ACC_W-1:0] RND =
    {{(ACC_W-COEF_W+1){1'b0}}, 1'b1, {(COEF_W-2){1'b0}}};
  localparam logic signed [ACC_W-1:0] RMAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] RMIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    WAIT = 2'd3
  } state_t;

  state_t                     state_q;
  logic signed [ACC_W-1:0]    acc_q   [NUM_CH];
  logic [AW-1:0]              tap_q;
  logic [AW-1:0]              addr_q;
  logic [NUM_CH*DATA_W-1:0]   data_q;
  logic                       vld_q;
  logic                       busy_q;
  logic                       abort_q;

  logic signed [PW-1:0]       prod    [NUM_CH];
  logic signed [ACC_W-1:0]    acc_d   [NUM_CH];
  logic signed [ACC_W-1:0]    rnd     [NUM_CH];
  logic signed [ACC_W-1:0]    shf     [NUM_CH];
  logic [NUM_CH*DATA_W-1:0]   data_d;

  // Per-channel product, running sum and rounded/clamped result of that sum.
  always_comb begin
    data_d = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      prod[c]  = PW'($signed(smpl_in[c*DATA_W +: DATA_W])) * PW'($signed(coef));
      acc_d[c] = acc_q[c] + ACC_W'(prod[c]);
      rnd[c]   = acc_d[c] + RND;
      shf[c]   = rnd[c] >>> (COEF_W-1);
      if (SAT_EN != 0 && shf[c] > RMAX) begin
        data_d[c*DATA_W +: DATA_W] = RMAX[DATA_W-1:0];
      end else if (SAT_EN != 0 && shf[c] < RMIN) begin
        data_d[c*DATA_W +: DATA_W] = RMIN[DATA_W-1:0];
      end else begin
        data_d[c*DATA_W +: DATA_W] = shf[c][DATA_W-1:0];
      end
    end
  end

  // Control FSM with registered outputs; accumulators and result register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      for (int unsigned c = 0; c < NUM_CH; c++) acc_q[c] <= '0;
      tap_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      vld_q   <= 1'b0;
      abort_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sequencing) begin
            state_q <= RUN;
            for (int unsigned c = 0; c < NUM_CH; c++) acc_q[c] <= '0;
            tap_q   <= '0;
            addr_q  <= AW'(1);
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (!sequencing) begin
            state_q <= IDLE;
            tap_q   <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            abort_q <= 1'b1;
          end else if (tap_q == AW'(NUM_TAPS-1)) begin
            // Final tap: the result is taken from the sum including this product.
            state_q <= DONE;
            for (int unsigned c = 0; c < NUM_CH; c++) acc_q[c] <= acc_d[c];
            tap_q   <= '0;
            addr_q  <= '0;
            data_q  <= data_d;
            vld_q   <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            for (int unsigned c = 0; c < NUM_CH; c++) acc_q[c] <= acc_d[c];
            tap_q   <= tap_q + AW'(1);
            if (addr_q != AW'(NUM_TAPS-1)) addr_q <= addr_q + AW'(1);
          end
        end
        DONE: begin
          state_q <= sequencing ? WAIT : IDLE;
        end
        WAIT: begin
          if (!sequencing) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign coef_addr = addr_q;
  assign out_data  = data_q;
  assign out_vld   = vld_q;
  assign busy      = busy_q;
  assign abort     = abort_q;

endmodule

// File: doc/fir_mac_seq.md
FIR_MAC_SEQ -- requirements
Module: fir_mac_seq

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- NUM_TAPS, 1021, coefficients per run (>=2).
- NUM_CH, 2, parallel channels sharing one coefficient.
- DATA_W, 16, signed sample/result width.
- COEF_W, 16, signed coefficient width.
- ACC_W, 40, accumulator width (>= DATA_W+COEF_W).
- SAT_EN, 1, 1 = saturate output, 0 = truncate.
REQ-002 Ports (name direction width meaning) SHALL be:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- sequencing  in  1  high while samples stream in.
- smpl_in  in  NUM_CH*DATA_W  signed samples; ch c at [c*DATA_W +: DATA_W].
- coef  in  COEF_W  signed coefficient; external ROM, 1-cycle read latency.
- coef_addr  out  clog2(NUM_TAPS)  coefficient ROM address.
- out_data  out  NUM_CH*DATA_W  filtered results, same packing as smpl_in.
- out_vld  out  1  one-cycle pulse, out_data updated.
- busy  out  1  high in RUN.
- abort  out  1  one-cycle pulse, run cut short.
REQ-003 One clock only; reset is synchronous and active-low; ports named clk and rst_n.

Function
REQ-004 States SHALL be IDLE, RUN, DONE, WAIT; one-hot or binary is implementer's choice.
REQ-005 IDLE: coef_addr=0, busy=0; sequencing=1 -> RUN next edge, all accumulators cleared to 0 on that edge, coef_addr -> 1.
REQ-006 RUN cycle k (k=0..NUM_TAPS-1): acc[c] += coef*smpl_in[c] for every c; coef is ROM data for address k issued the previous cycle; smpl_in must carry tap-k sample that cycle.
REQ-007 RUN: coef_addr increments each cycle, saturating at NUM_TAPS-1 (no wrap); tap counter counts products accumulated.
REQ-008 RUN with k=NUM_TAPS-1 and sequencing=1 -> DONE; result registered on that edge.
REQ-009 DONE: out_vld=1 exactly one cycle; out_data holds the new results; next state WAIT if sequencing=1, else IDLE.
REQ-010 WAIT: no accumulation; sequencing=0 -> IDLE; a new run requires sequencing low for >=1 cycle.
REQ-011 sequencing=0 in any RUN cycle -> that cycle's product discarded, IDLE next edge, abort=1 for one cycle, out_vld stays 0, out_data unchanged.
REQ-012 Product: full COEF_W+DATA_W signed, sign-extended to ACC_W; accumulation wraps modulo 2^ACC_W.
REQ-013 Result per channel: (acc + 2^(COEF_W-2)) >>> (COEF_W-1) (arithmetic, round half up).
REQ-014 SAT_EN=1: clamp result to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; SAT_EN=0: keep low DATA_W bits.
REQ-015 out_data changes only on the edge entering DONE; held otherwise.
REQ-016 Channels SHALL be bit-exact independent; no cross-channel interaction.

Reset
REQ-017 rst_n=0 at an edge: state IDLE, accumulators 0, tap counter 0, coef_addr=0, out_data=0, out_vld=0, busy=0, abort=0.
REQ-018 Reset overrides all events incl. mid-RUN and DONE; no out_vld or abort pulse caused by reset.
REQ-019 First run after reset release requires sequencing sampled high in IDLE.

Verification (NUM_TAPS=4, NUM_CH=2, DATA_W=16, COEF_W=16, ACC_W=40)
REQ-020 rst_n low 2 cycles with sequencing=1 -> all outputs 0, busy 0 throughout.
REQ-021 coefs {0x4000,0x2000,0x1000,0x0800}; ch0 {1000,0,0,0}, ch1 {0,0,0,-2000} -> out_vld one cycle after 4th RUN cycle, ch0=500, ch1=-125.
REQ-022 coefs all 0x7FFF; ch0 all 0x7FFF, ch1 all 0x8000; SAT_EN=1 -> ch0=0x7FFF, ch1=0x8000; SAT_EN=0 -> low 16 bits of rounded shifted sums.
REQ-023 sequencing drops after 2 RUN cycles -> abort pulse 1 cycle, no out_vld, out_data keeps prior value, coef_addr=0 in IDLE.
REQ-024 sequencing held high 10 cycles -> exactly one out_vld, WAIT until low; low 1 cycle then high -> second run, accumulators restart from 0.
REQ-025 rst_n low in RUN cycle 2 -> IDLE next edge, all outputs 0, no out_vld or abort.
